// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_pkg
//  Description : Shared definitions for the pipeline hazard controller:
//                forward-select encodings, FSM state encoding, parameter
//                defaults and the operand-select priority function.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int CNT_WIDTH_DEF      = 32;
    localparam int MEM_TIMEOUT_DEF    = 255;

    // ID operand mux select encoding
    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,  // register file
        FWD_EX_ALU  = 2'b01,  // EX stage alu_out
        FWD_DMEM    = 2'b10,  // data memory read data
        FWD_MEM_ALU = 2'b11   // EX/MEM alu_out
    } fwd_sel_t;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    // Youngest producer wins. A load still in EX has no data yet, so it is
    // skipped here and handled by the load-use stall instead.
    function automatic fwd_sel_t fwd_select(
        input logic ex_hit,
        input logic ex_is_load,
        input logic mem_hit,
        input logic mem_is_load
    );
        if (ex_hit && !ex_is_load) begin
            return FWD_EX_ALU;
        end else if (mem_hit && mem_is_load) begin
            return FWD_DMEM;
        end else if (mem_hit) begin
            return FWD_MEM_ALU;
        end
        return FWD_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundle of pipeline status inputs and control outputs of the
//                hazard controller.
//  Ports       : master - pipeline side (drives ID/EX/MEM status, dmem_ready,
//                         IF_flush_in; receives enables, selects, counters)
//                slave  - hazard controller side
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF
);
    // ID stage consumer
    logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1;
    logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2;
    logic                      id_use_rs1;
    logic                      id_use_rs2;
    // EX stage producer
    logic [REG_ADDR_WIDTH-1:0] ID_EX_rd;
    logic                      ID_EX_reg_wr_en;
    logic                      ID_EX_mem_read;
    // MEM stage producer
    logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd;
    logic                      EX_MEM_reg_wr_en;
    logic                      EX_MEM_mem_read;
    logic                      EX_MEM_mem_access;
    logic                      dmem_ready;
    logic                      IF_flush_in;
    // Controls
    logic                      pc_write;
    logic                      IF_ID_write;
    logic                      ID_EX_bubble;
    logic                      pipe_freeze;
    logic                      IF_flush;
    logic [1:0]                forward_comp1;
    logic [1:0]                forward_comp2;
    logic                      mem_timeout;
    logic [CNT_WIDTH-1:0]      stall_cnt;
    logic [CNT_WIDTH-1:0]      flush_cnt;

    modport master (
        output IF_ID_rs1, IF_ID_rs2, id_use_rs1, id_use_rs2,
        output ID_EX_rd, ID_EX_reg_wr_en, ID_EX_mem_read,
        output EX_MEM_rd, EX_MEM_reg_wr_en, EX_MEM_mem_read, EX_MEM_mem_access,
        output dmem_ready, IF_flush_in,
        input  pc_write, IF_ID_write, ID_EX_bubble, pipe_freeze, IF_flush,
        input  forward_comp1, forward_comp2, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, id_use_rs1, id_use_rs2,
        input  ID_EX_rd, ID_EX_reg_wr_en, ID_EX_mem_read,
        input  EX_MEM_rd, EX_MEM_reg_wr_en, EX_MEM_mem_read, EX_MEM_mem_access,
        input  dmem_ready, IF_flush_in,
        output pc_write, IF_ID_write, ID_EX_bubble, pipe_freeze, IF_flush,
        output forward_comp1, forward_comp2, mem_timeout, stall_cnt, flush_cnt
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones.
//  Ports       : clk   - clock, rising edge
//                rst   - synchronous active-high clear
//                inc   - count enable
//                count - current value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller. Generates ID operand forward
//                selects, load-use stalls, data-memory wait freezes with a
//                timeout, gated IF flush and stall/flush performance counters.
//  Ports       : clk     - clock, rising edge
//                reset_n - synchronous reset, active HIGH despite the name
//                bus     - hazard_ctrl_if.slave (pipeline status in,
//                          enables/selects/flags/counters out)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
    parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    hazard_ctrl_if.slave bus
);

    localparam int                        WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]         WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [REG_ADDR_WIDTH-1:0] REG_X0     = '0;

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;

    logic w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
    logic w_load_use;
    logic w_freeze;
    logic w_timeout;
    logic w_pc_write, w_if_id_write, w_bubble, w_if_flush;

    // ------------------------------------------------------------------
    // Producer/consumer matching. Writes to x0 are never real results.
    // MEM/WB producers are intentionally absent: the register file
    // writes through in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_ex_hit1  = bus.ID_EX_reg_wr_en && (bus.ID_EX_rd != REG_X0)
                     && (bus.ID_EX_rd == bus.IF_ID_rs1) && bus.id_use_rs1;
        w_ex_hit2  = bus.ID_EX_reg_wr_en && (bus.ID_EX_rd != REG_X0)
                     && (bus.ID_EX_rd == bus.IF_ID_rs2) && bus.id_use_rs2;
        w_mem_hit1 = bus.EX_MEM_reg_wr_en && (bus.EX_MEM_rd != REG_X0)
                     && (bus.EX_MEM_rd == bus.IF_ID_rs1) && bus.id_use_rs1;
        w_mem_hit2 = bus.EX_MEM_reg_wr_en && (bus.EX_MEM_rd != REG_X0)
                     && (bus.EX_MEM_rd == bus.IF_ID_rs2) && bus.id_use_rs2;
        w_load_use = (w_ex_hit1 || w_ex_hit2) && bus.ID_EX_mem_read;
    end

    // Selects are independent of stall/freeze so they stay valid while
    // the pipeline is held.
    assign bus.forward_comp1 = fwd_select(w_ex_hit1, bus.ID_EX_mem_read,
                                          w_mem_hit1, bus.EX_MEM_mem_read);
    assign bus.forward_comp2 = fwd_select(w_ex_hit2, bus.ID_EX_mem_read,
                                          w_mem_hit2, bus.EX_MEM_mem_read);

    // ------------------------------------------------------------------
    // Memory-wait FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM: next state and pipeline controls.
    // The freeze is released combinationally in the cycle dmem_ready rises
    // (or the wait times out) so the held access retires that same cycle
    // and does not immediately re-trigger a wait from RUN.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_freeze      = 1'b0;
        w_timeout     = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (bus.EX_MEM_mem_access && !bus.dmem_ready) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    w_state_nxt = ST_RUN;
                end else if (r_wait_cnt == WAIT_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_freeze    = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        // Priority: freeze > load-use stall > flush
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_bubble      = 1'b0;
        w_if_flush    = bus.IF_flush_in;
        if (w_freeze) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_if_flush    = 1'b0;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
            w_if_flush    = 1'b0;
        end
    end

    // Wait counter holds the ordinal of the current MEM_WAIT cycle (1 on
    // the first), so the access is frozen for MEM_TIMEOUT cycles in total
    // (the RUN cycle that detected it plus MEM_TIMEOUT-1 waiting cycles)
    // before the timeout cycle releases it.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                r_wait_cnt <= WAIT_W'(1);
            end else if (w_state_nxt == ST_MEM_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_timeout) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.IF_ID_write  = w_if_id_write;
    assign bus.ID_EX_bubble = w_bubble;
    assign bus.pipe_freeze  = w_freeze;
    assign bus.IF_flush     = w_if_flush;
    assign bus.mem_timeout  = r_mem_timeout;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (reset_n),
        .inc   (~w_pc_write),
        .count (bus.stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (reset_n),
        .inc   (w_if_flush),
        .count (bus.flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Expected outputs are
//                queued per cycle as stimulus is applied and compared mid-cycle.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int RAW = 5;
    localparam int CW  = 4;
    localparam int MT  = 6;

    typedef struct packed {
        logic          pcw;
        logic          ifidw;
        logic          bub;
        logic          frz;
        logic          fl;
        logic [1:0]    f1;
        logic [1:0]    f2;
        logic          to;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) bus ();

    hazard_ctrl #(
        .REG_ADDR_WIDTH (RAW),
        .CNT_WIDTH      (CW),
        .MEM_TIMEOUT    (MT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    obs_t          exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] m_stall  = '0;
    logic [CW-1:0] m_flush  = '0;
    logic          m_to     = 1'b0;
    obs_t          got;
    obs_t          e;

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input logic [RAW-1:0] rs1, input logic u1,
                          input logic [RAW-1:0] rs2, input logic u2);
        bus.IF_ID_rs1  = rs1;
        bus.id_use_rs1 = u1;
        bus.IF_ID_rs2  = rs2;
        bus.id_use_rs2 = u2;
    endtask

    task automatic set_ex(input logic [RAW-1:0] rd, input logic wr, input logic mr);
        bus.ID_EX_rd        = rd;
        bus.ID_EX_reg_wr_en = wr;
        bus.ID_EX_mem_read  = mr;
    endtask

    task automatic set_mem(input logic [RAW-1:0] rd, input logic wr, input logic mr,
                           input logic acc, input logic rdy);
        bus.EX_MEM_rd         = rd;
        bus.EX_MEM_reg_wr_en  = wr;
        bus.EX_MEM_mem_read   = mr;
        bus.EX_MEM_mem_access = acc;
        bus.dmem_ready        = rdy;
    endtask

    task automatic idle_in();
        set_id(5'd0, 1'b0, 5'd0, 1'b0);
        set_ex(5'd0, 1'b0, 1'b0);
        set_mem(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        bus.IF_flush_in = 1'b0;
    endtask

    // Queue the expected outputs for the cycle being driven; the counter
    // model then advances as the counters will at the coming edge.
    task automatic push_exp(input logic pcw, input logic ifidw, input logic bub,
                            input logic frz, input logic fl,
                            input logic [1:0] f1, input logic [1:0] f2);
        obs_t x;
        x = {pcw, ifidw, bub, frz, fl, f1, f2, m_to, m_stall, m_flush};
        exp_q.push_back(x);
        if (!pcw && (m_stall != '1)) m_stall = m_stall + 1'b1;
        if (fl && (m_flush != '1))   m_flush = m_flush + 1'b1;
    endtask

    function automatic obs_t sample();
        return {bus.pc_write, bus.IF_ID_write, bus.ID_EX_bubble, bus.pipe_freeze,
                bus.IF_flush, bus.forward_comp1, bus.forward_comp2,
                bus.mem_timeout, bus.stall_cnt, bus.flush_cnt};
    endfunction

    task automatic do_reset();
        reset_n = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        m_stall = '0;
        m_flush = '0;
        m_to    = 1'b0;
    endtask

    // ---------------- tests ----------------
    // Fields printed: pcw ifidw bubble freeze flush f1 f2 timeout stall_cnt flush_cnt
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            idle_in();
            if (i == 1) set_ex(5'd0, 1'b1, 1'b1);  // x0 load never stalls
            push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
            #3;
            got = sample();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL reset[%0d]: got %b required %b", i, got, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            idle_in();
            case (i)
                0: begin  // load x5 in EX, ID reads x5
                    set_id(5'd5, 1'b1, 5'd3, 1'b1);
                    set_ex(5'd5, 1'b1, 1'b1);
                    push_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
                end
                1: begin  // retry: load now in MEM, bubble in EX
                    set_id(5'd5, 1'b1, 5'd3, 1'b1);
                    set_mem(5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
                    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
                end
                2: begin  // rs2 matches load but is unused
                    set_id(5'd0, 1'b0, 5'd6, 1'b0);
                    set_ex(5'd6, 1'b1, 1'b1);
                    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
                end
                default: begin  // rs2 in use -> load-use
                    set_id(5'd0, 1'b0, 5'd6, 1'b1);
                    set_ex(5'd6, 1'b1, 1'b1);
                    push_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
                end
            endcase
            #3;
            got = sample();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL load_use[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL load_use[%0d]: got %b required %b", i, got, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        for (int i = 0; i < 5; i++) begin
            idle_in();
            case (i)
                0: begin  // x7 in EX and MEM: youngest wins
                    set_id(5'd1, 1'b1, 5'd7, 1'b1);
                    set_ex(5'd7, 1'b1, 1'b0);
                    set_mem(5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
                    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01);
                end
                1: begin  // x0 never forwarded
                    set_id(5'd0, 1'b1, 5'd0, 1'b1);
                    set_ex(5'd0, 1'b1, 1'b0);
                    set_mem(5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
                    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
                end
                2: begin  // EX not writing; MEM ALU result
                    set_id(5'd9, 1'b1, 5'd2, 1'b1);
                    set_ex(5'd9, 1'b0, 1'b0);
                    set_mem(5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
                    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
                end
                3: begin  // both operands from EX over a MEM load
                    set_id(5'd9, 1'b1, 5'd9, 1'b1);
                    set_ex(5'd9, 1'b1, 1'b0);
                    set_mem(5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
                    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
                end
                default: begin  // MEM load to rs1; rs2 same reg but unused
                    set_id(5'd4, 1'b1, 5'd4, 1'b0);
                    set_ex(5'd5, 1'b1, 1'b0);
                    set_mem(5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
                    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
                end
            endcase
            #3;
            got = sample();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL forward[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL forward[%0d]: got %b required %b", i, got, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 5; i++) begin
            idle_in();
            set_id(5'd8, 1'b1, 5'd0, 1'b0);
            set_ex(5'd8, 1'b1, 1'b0);
            if (i <= 3) set_mem(5'd0, 1'b0, 1'b0, 1'b1, (i == 3));  // store
            else        set_mem(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            case (i)
                0: push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
                1: begin  // load-use under freeze: freeze wins
                    set_ex(5'd8, 1'b1, 1'b1);
                    push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
                end
                2: begin  // flush request under freeze is gated
                    bus.IF_flush_in = 1'b1;
                    push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
                end
                3: push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
                default: push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
            endcase
            #3;
            got = sample();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mem_wait[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL mem_wait[%0d]: got %b required %b", i, got, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_priority();
        for (int i = 0; i < 3; i++) begin
            idle_in();
            case (i)
                0: begin
                    bus.IF_flush_in = 1'b1;
                    set_id(5'd5, 1'b1, 5'd0, 1'b0);
                    set_ex(5'd5, 1'b1, 1'b1);
                    push_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
                end
                1: begin
                    bus.IF_flush_in = 1'b1;
                    set_id(5'd5, 1'b1, 5'd0, 1'b0);
                    set_mem(5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
                    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
                end
                default: push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
            endcase
            #3;
            got = sample();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL flush_prio[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL flush_prio[%0d]: got %b required %b", i, got, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        // MT frozen cycles, then the release cycle, then mem_timeout visible;
        // then three more frozen cycles interrupted by reset.
        for (int i = 0; i < MT + 5; i++) begin
            idle_in();
            if (i <= MT || i > MT + 1) set_mem(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i < MT || i > MT + 1) begin
                push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
            end else begin
                push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
                if (i == MT) m_to = 1'b1;
            end
            #3;
            got = sample();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL timeout[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL timeout[%0d]: got %b required %b", i, got, e);
                end
            end
            @(posedge clk); #1;
        end
        // Reset mid-wait while dmem_ready stays low
        reset_n = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        m_stall = '0;
        m_flush = '0;
        m_to    = 1'b0;
        // In RUN with no access, dmem_ready low must not freeze
        idle_in();
        set_mem(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        #3;
        got = sample();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL timeout_reset: scoreboard empty");
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL timeout_reset: got %b required %b", got, e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 37; i++) begin
            idle_in();
            if (i < 18) begin
                set_id(5'd5, 1'b1, 5'd0, 1'b0);
                set_ex(5'd5, 1'b1, 1'b1);
                push_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
            end else if (i < 36) begin
                bus.IF_flush_in = 1'b1;
                push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
            end else begin
                push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
            end
            #3;
            got = sample();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL saturation[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL saturation[%0d]: got %b required %b", i, got, e);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_n = 1'b1;
        idle_in();
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_flush_priority();
        test_timeout();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
